// File: rtl/capture_ctrl.sv
// Stereo camera capture sequencer: aligns capture to frame boundaries, writes
// {DATA_L, DATA_R} into the write bank, checks geometry and swaps banks on good frames.
module capture_ctrl #(
    parameter int PIXEL_WIDTH = 8,
    parameter int PIX_HACT    = 640,
    parameter int PIX_VACT    = 480,
    parameter int ADDR_WIDTH  = 19
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CMD_START,
    input  logic                     CMD_SINGLE,
    input  logic                     CMD_STOP,
    input  logic                     ERR_CLR,
    input  logic                     FVAL,
    input  logic                     LVAL,
    input  logic                     DVAL,
    input  logic [PIXEL_WIDTH-1:0]   DATA_L,
    input  logic [PIXEL_WIDTH-1:0]   DATA_R,
    output logic                     WR_EN,
    output logic [ADDR_WIDTH-1:0]    WR_ADDR,
    output logic [2*PIXEL_WIDTH-1:0] WR_DATA,
    output logic                     WR_BANK,
    output logic                     RD_BANK,
    output logic                     RD_VALID,
    output logic                     FRAME_DONE,
    output logic [7:0]               FRAME_CNT,
    output logic                     BUSY,
    output logic                     ERR_HCNT,
    output logic                     ERR_VCNT
);

    // Counters are two bits wider than needed and saturate, so overlong lines/frames never alias to a good count
    localparam int CW = $clog2(PIX_HACT) + 2;
    localparam int LW = $clog2(PIX_VACT) + 2;
    localparam logic [CW-1:0]         HACT_C = CW'(PIX_HACT);
    localparam logic [LW-1:0]         VACT_C = LW'(PIX_VACT);
    localparam logic [ADDR_WIDTH-1:0] HACT_A = ADDR_WIDTH'(PIX_HACT);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE} state_t;

    state_t state, state_nxt;

    logic                  fval_d, lval_d;
    logic                  single_mode, stop_pend, frame_bad;
    logic [CW-1:0]         col;
    logic [LW-1:0]         line, line_nxt;
    logic [ADDR_WIDTH-1:0] line_base;
    logic                  fr, ff, lf;
    logic                  capturing, sample, in_window, lf_fire;
    logic                  hcnt_bad, vcnt_bad, frame_good;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:
                if (!CMD_STOP && (CMD_START || CMD_SINGLE)) state_nxt = WAIT_FRAME;
            WAIT_FRAME:
                if (CMD_STOP)  state_nxt = IDLE;
                else if (fr)   state_nxt = CAPTURE;
            CAPTURE:
                if (ff) begin
                    if (stop_pend || CMD_STOP || (single_mode && frame_good)) state_nxt = IDLE;
                    else                                                      state_nxt = WAIT_FRAME;
                end
            default: state_nxt = IDLE;
        endcase
    end

    // A line end coinciding with the frame end still counts toward the line total
    always_comb begin
        fr         = FVAL & ~fval_d;
        ff         = ~FVAL & fval_d;
        lf         = ~LVAL & lval_d;
        capturing  = (state == CAPTURE);
        sample     = capturing & FVAL & DVAL;
        in_window  = (col < HACT_C) && (line < VACT_C);
        lf_fire    = capturing & lf & (col != '0);
        hcnt_bad   = lf_fire & (col != HACT_C);
        line_nxt   = (lf_fire && (line != '1)) ? line + 1'b1 : line;
        vcnt_bad   = capturing & ff & (line_nxt != VACT_C);
        frame_good = ~(frame_bad | hcnt_bad | vcnt_bad);
        BUSY       = (state != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fval_d      <= 1'b1;
            lval_d      <= 1'b1;
            single_mode <= 1'b0;
            stop_pend   <= 1'b0;
            frame_bad   <= 1'b0;
            col         <= '0;
            line        <= '0;
            line_base   <= '0;
            WR_EN       <= 1'b0;
            WR_ADDR     <= '0;
            WR_DATA     <= '0;
            WR_BANK     <= 1'b0;
            RD_BANK     <= 1'b1;
            RD_VALID    <= 1'b0;
            FRAME_DONE  <= 1'b0;
            FRAME_CNT   <= '0;
            ERR_HCNT    <= 1'b0;
            ERR_VCNT    <= 1'b0;
        end else begin
            fval_d     <= FVAL;
            lval_d     <= LVAL;
            WR_EN      <= sample & in_window;
            FRAME_DONE <= 1'b0;
            if (sample) begin
                WR_ADDR <= line_base + ADDR_WIDTH'(col);
                WR_DATA <= {DATA_L, DATA_R};
            end

            if (state == IDLE && state_nxt == WAIT_FRAME) single_mode <= CMD_SINGLE;

            if (state_nxt == IDLE)          stop_pend <= 1'b0;
            else if (capturing && CMD_STOP) stop_pend <= 1'b1;

            if (state == WAIT_FRAME && fr) begin
                col       <= '0;
                line      <= '0;
                line_base <= '0;
                frame_bad <= 1'b0;
            end else if (capturing) begin
                frame_bad <= ~frame_good;
                line      <= line_nxt;
                if (lf_fire) begin
                    col       <= '0;
                    line_base <= line_base + HACT_A;
                end else if (sample && (col != '1)) begin
                    col <= col + 1'b1;
                end
                if (ff && frame_good) begin
                    WR_BANK    <= ~WR_BANK;
                    RD_BANK    <= WR_BANK;
                    RD_VALID   <= 1'b1;
                    FRAME_CNT  <= FRAME_CNT + 1'b1;
                    FRAME_DONE <= 1'b1;
                end
            end

            if (hcnt_bad)     ERR_HCNT <= 1'b1;
            else if (ERR_CLR) ERR_HCNT <= 1'b0;
            if (vcnt_bad)     ERR_VCNT <= 1'b1;
            else if (ERR_CLR) ERR_VCNT <= 1'b0;
        end
    end

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
Sequences capture of the stereo camera stream (FVAL/LVAL/DVAL, DATA_L/DATA_R) into a two-bank frame buffer, with the VGA reader on the other bank. Handles start, single-shot and stop commands, aligns capture to frame boundaries, generates write addresses, checks line/frame geometry and swaps banks on each good frame. Sits between the camera input register stage (already in the CLK domain) and the frame-buffer memory.

Parameters:
PIXEL_WIDTH, 8, bits per pixel per eye
PIX_HACT, 640, expected DVAL-qualified pixels per line
PIX_VACT, 480, expected active lines per frame
ADDR_WIDTH, 19, frame-buffer word address width per bank; must satisfy 2^ADDR_WIDTH >= PIX_HACT*PIX_VACT

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous reset, active-high
CMD_START  in  1  1-cycle pulse: continuous capture
CMD_SINGLE  in  1  1-cycle pulse: capture one good frame
CMD_STOP  in  1  1-cycle pulse: stop at next frame end
ERR_CLR  in  1  clear sticky error flags
FVAL  in  1  frame valid
LVAL  in  1  line valid
DVAL  in  1  data valid
DATA_L  in  PIXEL_WIDTH  left-eye pixel
DATA_R  in  PIXEL_WIDTH  right-eye pixel
WR_EN  out  1  frame-buffer write strobe
WR_ADDR  out  ADDR_WIDTH  word address in WR_BANK
WR_DATA  out  2*PIXEL_WIDTH  {DATA_L, DATA_R}
WR_BANK  out  1  bank being written
RD_BANK  out  1  last completed bank for VGA reader
RD_VALID  out  1  RD_BANK holds a good frame
FRAME_DONE  out  1  1-cycle pulse on bank swap
FRAME_CNT  out  8  good frames captured, wraps 255->0
BUSY  out  1  state != IDLE
ERR_HCNT  out  1  sticky: line length != PIX_HACT
ERR_VCNT  out  1  sticky: line count != PIX_VACT

Behaviour:
- Reset: all outputs 0 except RD_BANK=1; state IDLE; internal fval_d=1, lval_d=1 (a FVAL already high at reset is never a rising edge).
- Edges: fr = FVAL&~fval_d, ff = ~FVAL&fval_d; lf = ~LVAL&lval_d.
- States: IDLE, WAIT_FRAME, CAPTURE.
- IDLE: CMD_START or CMD_SINGLE -> WAIT_FRAME, latch mode (single if CMD_SINGLE; both set -> single). CMD_STOP in the same cycle wins: stay IDLE.
- WAIT_FRAME: on fr -> CAPTURE, clear col/line/addr counters. CMD_STOP -> IDLE immediately. Partial frame in progress on entry is skipped.
- CAPTURE: sample with FVAL&DVAL at cycle n -> WR_EN=1 at n+1, WR_DATA = data of cycle n, WR_ADDR = line*PIX_HACT+col (incrementing counter, no multiplier), then col++. Writes with col>=PIX_HACT or line>=PIX_VACT are suppressed (no WR_EN), counting continues for checks.
- On lf with col>0: if col!=PIX_HACT set ERR_HCNT and frame-bad; line++; col=0. lf with col==0 ignored.
- On ff: if line!=PIX_VACT set ERR_VCNT and frame-bad. Good frame: RD_BANK<=WR_BANK, WR_BANK<=~WR_BANK, RD_VALID<=1, FRAME_CNT++, FRAME_DONE=1 next cycle. Bad frame: no swap, no count, no pulse; bank rewritten next frame.
- After ff: stop pending -> IDLE; single mode and good frame -> IDLE; otherwise -> WAIT_FRAME (bad single-shot retries).
- CMD_STOP in CAPTURE sets stop-pending; current frame completes. CMD_START/CMD_SINGLE while BUSY ignored.
- ERR_CLR clears ERR_*; same-cycle set wins. Errors never stop capture.
- RST mid-frame: immediate return to reset values; RD_VALID drops; next capture waits for fresh fr.

Test Plan:
- PIX_HACT=8, PIX_VACT=4; CMD_SINGLE then clean 8x4 frame, DATA_R=n, DATA_L=n+16 -> 32 writes, addr 0..31, WR_BANK=0, FRAME_DONE once, RD_BANK=0, RD_VALID=1, FRAME_CNT=1, back to IDLE.
- CMD_START issued with FVAL high mid-frame -> no writes until next FVAL rise; 3 clean frames -> WR_BANK toggles 0,1,0,1, FRAME_CNT=3.
- One line of 7 pixels -> ERR_HCNT=1, no swap, FRAME_CNT unchanged; next clean frame swaps; ERR_CLR -> ERR_HCNT=0.
- Frame of 5 lines with 10-pixel lines -> ERR_VCNT=ERR_HCNT=1, only addr 0..31 written, no FRAME_DONE.
- CMD_STOP mid-frame -> current frame completes, swaps, then IDLE; CMD_START+CMD_STOP same cycle in IDLE -> stays IDLE.
- RST asserted mid-frame -> outputs at reset values next cycle, RD_BANK=1, RD_VALID=0; FRAME_CNT wrap 255->0 checked with 256 frames.
